lif_tdm_scheduler: RTL and testbench
====================================

# lif_tdm_scheduler

Time-multiplexed scheduler for a single shared leaky integrate-and-fire update datapath, serving `N_NEURONS` virtual neurons. It holds per-neuron membrane state and input current in local register files. On each timestep pulse it sequences every neuron through the shared update, one neuron per cycle. It emits a spike event stream and a per-timestep completion pulse to the surrounding network logic.

## Interface
- `N_NEURONS`, 8: number of virtual neurons; power of two, 2..64.
- `WIDTH`, 8: membrane/current width in bits.
- `THR_RESET`, 230: threshold value loaded at reset.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `step` in 1: start-timestep pulse; sampled every cycle.
- `cur_we` in 1: current write strobe.
- `cur_addr` in log2(N_NEURONS): neuron index for the current write.
- `cur_data` in WIDTH: input current value.
- `thr_we` in 1: threshold write strobe.
- `thr_data` in WIDTH: new threshold.
- `busy` out 1: timestep sweep in progress.
- `done` out 1: one-cycle pulse at the end of a sweep.
- `spike_valid` out 1: spike event valid, one cycle per event.
- `spike_id` out log2(N_NEURONS): index of the spiking neuron.
- `overrun` out 1: sticky; set when `step` arrives while busy.

## Operation
- FSM states:
  - IDLE: `step`=1 → SWEEP, index cleared to 0.
  - SWEEP: processes neuron[index], then increments the index. After index N_NEURONS-1 it goes to DONE.
  - DONE: asserts `done` for one cycle, then → IDLE.
- Per-neuron update, with s = state[i] and c = current[i]:
  - spike = (s >= thr).
  - If spike, the next state is 0.
  - Otherwise the next state is sat(c + (s>>1) + (s>>2) + (s>>3)).
  - The sum is formed WIDTH+1 bits wide and saturates to 2^WIDTH-1. It never wraps.
- The spike decision uses the state stored from the previous timestep. The threshold compare is unsigned.
- Currents persist across timesteps; they are not cleared after use. A write replaces the stored value.
- Current write landing in the same cycle that neuron is being processed: the update uses the old current, and the new value is stored for the next timestep.
- Current writes to any index are accepted in every state.
- `thr_we` is honoured only in IDLE and is silently ignored otherwise. The threshold is therefore constant across a sweep.
- `step` in SWEEP or DONE is dropped and sets `overrun`. Only reset clears `overrun`.
- `thr_we` together with `step` in IDLE: the new threshold is stored and applies to the sweep being started.

## Timing
- Reset values:
  - states: all state[i] = 0, all current[i] = 0, thr = THR_RESET.
  - outputs: `busy`=0, `done`=0, `spike_valid`=0, `spike_id`=0, `overrun`=0.
  - FSM: IDLE, index 0.
- `step` sampled high at edge t (in IDLE) causes:
  - `busy`=1 from cycle t+1 through cycle t+N_NEURONS+1 inclusive;
  - neuron i processed in cycle t+1+i, with its state written at the end of that cycle;
  - `done`=1 in cycle t+N_NEURONS+1, with `busy` still 1 in that cycle.
- `spike_valid`/`spike_id` are registered. A spike of neuron i is reported in cycle t+2+i, so the last event can coincide with `done`.
- Back-to-back timesteps: earliest accepted `step` is in the cycle after `done`. The sweep period is N_NEURONS+2 cycles.
- Reset asserted mid-sweep: everything returns to reset values at that edge. There is no `done`, and no further spike events.
- Spike events are emitted in ascending index order, at most one per cycle.

## Structure
- Shared package `lif_pkg` holds:
  - `WIDTH` default and `THR_RESET` default;
  - the FSM state enum (IDLE, SWEEP, DONE);
  - the saturating-add helper function.
- Natural sub-module: `lif_update`, purely combinational. It takes state, current and threshold and produces next_state and spike. The scheduler instantiates it once.
- State and current register files live in the scheduler, implemented as flops; there is no RAM macro at these sizes.

## Test plan
- Reset values: N=4, hold `rst_n`=0 two cycles → all outputs at reset values, threshold 230, no spikes.
- Integrate and saturate, `current[0]`=100, four steps:
  - state0 sequence is 100, 187, 255 (saturated from 262);
  - 4th step: `spike_valid` with `spike_id`=0 at t+2, and state0 → 0.
- Cycle timing: one `step` with N=4 → `busy` for cycles t+1..t+5, `done` only in t+5, and a further step in t+2 sets `overrun`=1 and starts no sweep.
- Threshold and concurrency:
  - `thr_we` `thr_data`=50 during a sweep is ignored;
  - the same write in IDLE takes effect;
  - `current[1]`=60 → spike on the 2nd step;
  - a current write to index 2 in its processing cycle uses the old value.
- Multiple spikes: all four neurons at state ≥ thr → `spike_id` 0,1,2,3 on consecutive cycles t+2..t+5.
- Reset mid-sweep: `rst_n`=0 in cycle t+2 → no `done`, all states 0, `busy`=0 the next cycle.

Source files
------------

// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared defaults, FSM state type and saturating add for the LIF scheduler
package lif_pkg;

    localparam int LIF_WIDTH     = 8;
    localparam int LIF_THR_RESET = 230;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } lif_state_e;

    // Adds two values one bit wider than w and clamps to 2^w-1 (w <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? 32'(lim) : 32'(sum);
    endfunction

endpackage

// File: rtl/lif_tdm_scheduler_if.sv
// rtl/lif_tdm_scheduler_if.sv - configuration write bus and spike event stream
interface lif_tdm_scheduler_if
    import lif_pkg::*;
#(
    parameter int N_NEURONS = 8,
    parameter int WIDTH     = LIF_WIDTH
);
    localparam int IDX_W = $clog2(N_NEURONS);

    logic             cur_we;
    logic [IDX_W-1:0] cur_addr;
    logic [WIDTH-1:0] cur_data;
    logic             thr_we;
    logic [WIDTH-1:0] thr_data;
    logic             spike_valid;
    logic [IDX_W-1:0] spike_id;

    modport master (
        output cur_we, cur_addr, cur_data, thr_we, thr_data,
        input  spike_valid, spike_id
    );

    modport slave (
        input  cur_we, cur_addr, cur_data, thr_we, thr_data,
        output spike_valid, spike_id
    );

endinterface

// File: rtl/lif_update.sv
// rtl/lif_update.sv - combinational leaky integrate-and-fire update for one neuron
module lif_update
    import lif_pkg::*;
#(
    parameter int WIDTH = LIF_WIDTH
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] thr,
    output logic [WIDTH-1:0] next_state,
    output logic             spike
);

    logic [31:0] leak;

    always_comb begin
        spike = (state >= thr);
        // Leak keeps 7/8 of the membrane via three shifted copies.
        leak  = 32'(state >> 1) + 32'(state >> 2) + 32'(state >> 3);
        if (spike) begin
            next_state = '0;
        end else begin
            next_state = WIDTH'(sat_add(32'(cur), leak, WIDTH));
        end
    end

endmodule

// File: rtl/lif_tdm_scheduler.sv
// rtl/lif_tdm_scheduler.sv - sweeps N virtual neurons through one shared LIF update per timestep
module lif_tdm_scheduler
    import lif_pkg::*;
#(
    parameter int               N_NEURONS = 8,
    parameter int               WIDTH     = LIF_WIDTH,
    parameter logic [WIDTH-1:0] THR_RESET = WIDTH'(LIF_THR_RESET)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step,
    lif_tdm_scheduler_if.slave   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    localparam int               IDX_W    = $clog2(N_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    lif_state_e       fsm_q, fsm_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] thr_q, thr_d;
    logic             overrun_q, overrun_d;
    logic             spike_valid_q, spike_valid_d;
    logic [IDX_W-1:0] spike_id_q, spike_id_d;
    logic [WIDTH-1:0] state_q [N_NEURONS];
    logic [WIDTH-1:0] state_d [N_NEURONS];
    logic [WIDTH-1:0] cur_q   [N_NEURONS];
    logic [WIDTH-1:0] cur_d   [N_NEURONS];

    logic [WIDTH-1:0] upd_next;
    logic             upd_spike;

    lif_update #(.WIDTH(WIDTH)) u_update (
        .state      (state_q[idx_q]),
        .cur        (cur_q[idx_q]),
        .thr        (thr_q),
        .next_state (upd_next),
        .spike      (upd_spike)
    );

    always_comb begin
        fsm_d         = fsm_q;
        idx_d         = idx_q;
        thr_d         = thr_q;
        overrun_d     = overrun_q;
        spike_valid_d = 1'b0;
        spike_id_d    = spike_id_q;
        state_d       = state_q;
        cur_d         = cur_q;

        // The update reads cur_q, so a write to the neuron in flight lands for the next timestep.
        if (bus.cur_we) begin
            cur_d[bus.cur_addr] = bus.cur_data;
        end

        if (step && (fsm_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (fsm_q)
            IDLE: begin
                if (bus.thr_we) begin
                    thr_d = bus.thr_data;
                end
                if (step) begin
                    fsm_d = SWEEP;
                    idx_d = '0;
                end
            end
            SWEEP: begin
                state_d[idx_q] = upd_next;
                spike_valid_d  = upd_spike;
                if (upd_spike) begin
                    spike_id_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    fsm_d = DONE;
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
                idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q         <= IDLE;
            idx_q         <= '0;
            thr_q         <= THR_RESET;
            overrun_q     <= 1'b0;
            spike_valid_q <= 1'b0;
            spike_id_q    <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                state_q[i] <= '0;
                cur_q[i]   <= '0;
            end
        end else begin
            fsm_q         <= fsm_d;
            idx_q         <= idx_d;
            thr_q         <= thr_d;
            overrun_q     <= overrun_d;
            spike_valid_q <= spike_valid_d;
            spike_id_q    <= spike_id_d;
            state_q       <= state_d;
            cur_q         <= cur_d;
        end
    end

    assign busy            = (fsm_q != IDLE);
    assign done            = (fsm_q == DONE);
    assign overrun         = overrun_q;
    assign bus.spike_valid = spike_valid_q;
    assign bus.spike_id    = spike_id_q;

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// tb/tb_lif_tdm_scheduler.sv - self-checking bench for lif_tdm_scheduler
module tb_lif_tdm_scheduler;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic step = 1'b0;
    logic busy, done, overrun;

    lif_tdm_scheduler_if #(.N_NEURONS(N), .WIDTH(W)) bus ();

    lif_tdm_scheduler #(.N_NEURONS(N), .WIDTH(W), .THR_RESET(8'd230)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (step),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int mstate [N];
    int mcur   [N];
    int mthr;
    bit mover;

    typedef struct {
        int cur0;
        int exp_state0;
        bit exp_spike0;
    } vec_t;
    vec_t vecs [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mstate[i] = 0;
            mcur[i]   = 0;
        end
        mthr  = 230;
        mover = 1'b0;
    endtask

    task automatic write_cur(input int a, input int d);
        bus.cur_we   = 1'b1;
        bus.cur_addr = 2'(a);
        bus.cur_data = 8'(d);
        tick();
        bus.cur_we = 1'b0;
        mcur[a]    = d;
    endtask

    task automatic write_thr(input int d);
        bus.thr_we   = 1'b1;
        bus.thr_data = 8'(d);
        tick();
        bus.thr_we = 1'b0;
        mthr       = d;
    endtask

    task automatic check_states(input string name);
        for (int i = 0; i < N; i++) begin
            chk(name, 32'(dut.state_q[i]), 32'(mstate[i]));
        end
    endtask

    // One timestep: step in the current cycle, optional side traffic during the sweep.
    task automatic run_sweep(input bit thr_step, input int thr_step_val, input bit thr_mid,
                             input bit wr_en, input int wr_k, input int wr_addr, input int wr_data,
                             input int extra_k, output logic [N-1:0] seen);
        int exp_next [N];
        bit exp_sp   [N];
        bit exp_v;
        int c, s, nxt;
        seen = '0;
        if (thr_step) mthr = thr_step_val;
        for (int i = 0; i < N; i++) begin
            s         = mstate[i];
            c         = (wr_en && wr_addr == i && wr_k < i) ? wr_data : mcur[i];
            exp_sp[i] = (s >= mthr);
            nxt       = c + s / 2 + s / 4 + s / 8;
            if (nxt > 255) nxt = 255;
            exp_next[i] = exp_sp[i] ? 0 : nxt;
        end

        step         = 1'b1;
        bus.thr_we   = thr_step;
        bus.thr_data = 8'(thr_step_val);
        tick();
        step       = 1'b0;
        bus.thr_we = 1'b0;

        for (int cyc = 1; cyc <= N + 1; cyc++) begin
            bus.cur_we   = wr_en && (wr_k == cyc - 1);
            bus.cur_addr = 2'(wr_addr);
            bus.cur_data = 8'(wr_data);
            bus.thr_we   = thr_mid && (cyc == 2);
            bus.thr_data = 8'd50;
            step         = (extra_k == cyc - 1);

            chk("busy_sweep", 32'(busy), 32'd1);
            chk("done_sweep", 32'(done), 32'(cyc == N + 1));
            exp_v = 1'b0;
            if (cyc >= 2) exp_v = exp_sp[cyc - 2];
            chk("spike_valid", 32'(bus.spike_valid), 32'(exp_v));
            if (exp_v) chk("spike_id", 32'(bus.spike_id), 32'(cyc - 2));
            if (bus.spike_valid === 1'b1) seen[bus.spike_id] = 1'b1;
            tick();
            bus.cur_we = 1'b0;
            bus.thr_we = 1'b0;
            step       = 1'b0;
        end

        chk("busy_after", 32'(busy), 32'd0);
        chk("done_after", 32'(done), 32'd0);
        chk("spike_after", 32'(bus.spike_valid), 32'd0);

        for (int i = 0; i < N; i++) mstate[i] = exp_next[i];
        if (wr_en) mcur[wr_addr] = wr_data;
        if (extra_k >= 0) mover = 1'b1;
        check_states("state_after_sweep");
        chk("overrun", 32'(overrun), 32'(mover));
        chk("thr", 32'(dut.thr_q), 32'(mthr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] seen;

        bus.cur_we   = 1'b0;
        bus.cur_addr = '0;
        bus.cur_data = '0;
        bus.thr_we   = 1'b0;
        bus.thr_data = '0;

        vecs[0] = '{cur0: 100, exp_state0: 100, exp_spike0: 1'b0};
        vecs[1] = '{cur0: -1,  exp_state0: 187, exp_spike0: 1'b0};
        vecs[2] = '{cur0: -1,  exp_state0: 255, exp_spike0: 1'b0};
        vecs[3] = '{cur0: -1,  exp_state0: 0,   exp_spike0: 1'b1};

        // Reset values
        model_reset();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_spike_valid", 32'(bus.spike_valid), 32'd0);
        chk("rst_spike_id", 32'(bus.spike_id), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_thr", 32'(dut.thr_q), 32'd230);
        check_states("rst_state");
        rst_n = 1'b1;
        tick();

        // Integrate and saturate, table driven
        for (int r = 0; r < 4; r++) begin
            if (vecs[r].cur0 >= 0) write_cur(0, vecs[r].cur0);
            run_sweep(1'b0, 0, 1'b0, 1'b0, 0, 0, 0, -1, seen);
            chk("tbl_state0", 32'(dut.state_q[0]), 32'(vecs[r].exp_state0));
            chk("tbl_spike0", 32'(seen[0]), 32'(vecs[r].exp_spike0));
        end

        // Step in cycle t+2 is dropped and flags overrun
        run_sweep(1'b0, 0, 1'b0, 1'b0, 0, 0, 0, 1, seen);
        for (int k = 0; k < 3; k++) begin
            chk("no_extra_sweep", 32'(busy), 32'd0);
            tick();
        end
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Threshold write during a sweep is ignored, then takes effect from IDLE
        run_sweep(1'b0, 0, 1'b1, 1'b0, 0, 0, 0, -1, seen);
        run_sweep(1'b0, 0, 1'b0, 1'b0, 0, 0, 0, -1, seen);
        chk("thr_mid_ignored_spike0", 32'(seen[0]), 32'd0);
        write_thr(50);
        write_cur(1, 60);
        run_sweep(1'b0, 0, 1'b0, 1'b0, 0, 0, 0, -1, seen);
        chk("n1_no_spike_first", 32'(seen[1]), 32'd0);
        run_sweep(1'b0, 0, 1'b0, 1'b0, 0, 0, 0, -1, seen);
        chk("n1_spike_second", 32'(seen[1]), 32'd1);

        // Current write to index 2 during its own processing cycle
        run_sweep(1'b0, 0, 1'b0, 1'b1, 2, 2, 77, -1, seen);
        chk("wr_same_cycle_old", 32'(dut.state_q[2]), 32'd0);
        run_sweep(1'b0, 0, 1'b0, 1'b0, 0, 0, 0, -1, seen);
        chk("wr_same_cycle_new", 32'(dut.state_q[2]), 32'd77);

        // Threshold write together with step
        run_sweep(1'b1, 10, 1'b0, 1'b0, 0, 0, 0, -1, seen);

        // Randomised timesteps against the model
        for (int it = 0; it < 25; it++) begin
            int nw;
            nw = int'($urandom_range(0, 2));
            for (int j = 0; j < nw; j++) write_cur(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) write_thr(int'($urandom_range(60, 255)));
            run_sweep(($urandom_range(0, 4) == 0), int'($urandom_range(60, 255)),
                      ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 1) == 1), int'($urandom_range(0, N)),
                      int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)),
                      ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, N)) : -1, seen);
        end

        // Reset asserted in cycle t+2 of a sweep
        write_thr(1);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_spike", 32'(bus.spike_valid), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        chk("midrst_thr", 32'(dut.thr_q), 32'd230);
        check_states("midrst_state");
        for (int k = 0; k < N + 2; k++) begin
            tick();
            chk("midrst_quiet_done", 32'(done), 32'd0);
            chk("midrst_quiet_spike", 32'(bus.spike_valid), 32'd0);
            chk("midrst_quiet_busy", 32'(busy), 32'd0);
        end

        // All four neurons above threshold spike on consecutive cycles
        write_thr(30);
        for (int i = 0; i < N; i++) write_cur(i, 40);
        run_sweep(1'b0, 0, 1'b0, 1'b0, 0, 0, 0, -1, seen);
        chk("multi_pre_mask", 32'(seen), 32'd0);
        run_sweep(1'b0, 0, 1'b0, 1'b0, 0, 0, 0, -1, seen);
        chk("multi_mask", 32'(seen), 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
